// File: rtl/sid_boxcar_decimator.sv
// sid_boxcar_decimator
//   Bridges the 1 MHz SID sample stream to the I2S frame rate. A 2^LOG2_N-tap
//   running sum is kept in a small ring buffer. Each rising edge of the
//   asynchronous i2s_lrclk produces one averaged sample plus a strobe.
//   Optional feature macro: SID_DECIM_DCBLOCK_EN adds a one-pole DC blocker
//   (y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), saturated to IN_W).
//
//   Output protocol: out_strobe is a one-cycle pulse with no back-pressure.
//   out_sample and out_underrun are valid in the strobe cycle. out_sample holds
//   its value between strobes. out_underrun means no input sample arrived
//   since the previous strobe.
module sid_boxcar_decimator #(
  parameter int IN_W     = 16,
  parameter int LOG2_N   = 4,
  parameter int DC_SHIFT = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic signed [IN_W-1:0] in_sample,
  input  logic                   i2s_lrclk,
  output logic signed [IN_W-1:0] out_sample,
  output logic                   out_strobe,
  output logic                   out_underrun
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = IN_W + LOG2_N;

  logic signed [IN_W-1:0]  ring [N];
  logic [LOG2_N-1:0]       wr_ptr;
  logic [LOG2_N:0]         fill;
  logic signed [SUM_W-1:0] sum;
  logic                    seen_in;
  logic                    sync1;
  logic                    sync2;
  logic                    prev;

  logic                    rise;
  logic                    full;
  logic signed [IN_W-1:0]  oldest;
  logic signed [SUM_W-1:0] in_ext;
  logic signed [SUM_W-1:0] oldest_ext;
  logic signed [IN_W-1:0]  avg;
  logic signed [IN_W-1:0]  out_value;

  // Taps are only subtracted once the ring holds N real samples.
  // Until then, the stale RAM contents are masked to zero.
  assign full       = (fill == (LOG2_N+1)'(N));
  assign oldest     = full ? ring[wr_ptr] : '0;
  assign in_ext     = {{LOG2_N{in_sample[IN_W-1]}}, in_sample};
  assign oldest_ext = {{LOG2_N{oldest[IN_W-1]}}, oldest};
  assign rise       = sync2 & ~prev;

  // Arithmetic shift right by LOG2_N, then truncation to IN_W.
  // The result always fits because sum holds at most N full-scale samples.
  assign avg = sum[SUM_W-1:LOG2_N];

`ifdef SID_DECIM_DCBLOCK_EN
  localparam int Y_W = IN_W + 2;

  logic signed [IN_W-1:0] x_prev;
  logic signed [IN_W-1:0] y_prev;
  logic signed [IN_W-1:0] y_decay;
  logic signed [Y_W-1:0]  y_wide;
  logic signed [IN_W-1:0] y_sat;

  assign y_decay = y_prev >>> DC_SHIFT;
  assign y_wide  = Y_W'(avg) - Y_W'(x_prev) + Y_W'(y_prev) - Y_W'(y_decay);

  // Clamp the widened blocker output back into the signed IN_W range.
  always_comb begin
    y_sat = y_wide[IN_W-1:0];
    if (y_wide[Y_W-1:IN_W-1] != '0 && y_wide[Y_W-1:IN_W-1] != '1) begin
      if (y_wide[Y_W-1]) y_sat = {1'b1, {(IN_W-1){1'b0}}};
      else               y_sat = {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  assign out_value = y_sat;

  // Blocker history: previous input (avg) and previous saturated output.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (rise) begin
      x_prev <= avg;
      y_prev <= y_sat;
    end
  end
`else
  assign out_value = avg;
`endif

  // Ring buffer write. It is never reset; the fill count masks stale entries.
  always_ff @(posedge sys_clk) begin
    if (clk_en) ring[wr_ptr] <= in_sample;
  end

  // Running sum, lrclk edge detection, and the registered output stage.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sum          <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      seen_in      <= 1'b0;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      prev         <= 1'b1;
      out_sample   <= '0;
      out_strobe   <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      sync1      <= i2s_lrclk;
      sync2      <= sync1;
      prev       <= sync2;
      out_strobe <= rise;
      if (rise) begin
        // Reads the pre-update sum, so a coincident sample counts toward the next frame.
        out_sample   <= out_value;
        out_underrun <= ~seen_in;
      end
      if (clk_en) begin
        sum    <= sum + in_ext - oldest_ext;
        wr_ptr <= wr_ptr + LOG2_N'(1);
        if (!full) fill <= fill + (LOG2_N+1)'(1);
        seen_in <= 1'b1;
      end else if (rise) begin
        seen_in <= 1'b0;
      end
    end
  end

endmodule
